ixc_readback_13: RTL and testbench
==================================

# ixc_readback_13

Net-readback capture block: the reverse direction of the 13-bit assign/drive path, sampling a 13-bit emulated net bus back toward the host. On a capture strobe the current bus value is written into a small FIFO. A host-side valid/ready port drains the FIFO. Sits between the emulated design nets and the host readback channel in the same template library as the assign templates.

## Interface
Parameters:
- WIDTH, 13, sampled bus width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CNTW, 8, width of dropped-capture counter (saturating)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- R  in  WIDTH  net bus being read back (sampled, not driven)
- cap  in  1  capture strobe; one sample per cycle high
- clr  in  1  clears the overflow flag and drop counter (FIFO contents untouched)
- rd_valid  out  1  FIFO head available
- rd_data  out  WIDTH  FIFO head value
- rd_ready  in  1  host accepts head
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf  out  1  sticky; set when a capture is dropped
- drops  out  CNTW  number of dropped captures, saturates at all-ones

## Operation
- Capture: cap=1 and FIFO not full (or a pop happens the same cycle) → R written at the tail.
- Drop: cap=1 with FIFO full and no pop that cycle → sample discarded, ovf←1, drops increments unless saturated.
- Pop: rd_valid & rd_ready → head advances; rd_data shows the next entry the following cycle.
- Simultaneous push+pop when full → both occur; count unchanged; no drop.
- Simultaneous push+pop when empty → push only (rd_valid was 0); count 0→1.
- clr with a drop in the same cycle → drop wins: ovf=1, drops=1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty derive from count.
- rd_data while rd_valid=0 holds its last value (don't-care for checking).
- Reset mid-operation: all entries are logically discarded; a cap in the reset cycle is ignored.

## Timing
- Reset values: rd_valid=0, count=0, ovf=0, drops=0, rd_data=0, pointers=0.
- Capture-to-visible latency is 1 cycle. A cap at edge N on an empty FIFO gives rd_valid=1 and rd_data=R(N) after edge N.
- No fall-through and no combinational path from cap or R to the rd_* outputs. rd_ready reaches only the register enables.
- rd_valid may not drop without a pop.
- Throughput: one push and one pop per cycle sustained.
- Host handshake: rd_data is stable while rd_valid=1 and rd_ready=0.

## Structure
- Shared package ixc_readback_pkg: DEPTH/WIDTH defaults, the pointer-width function, and the count type.
- One sub-module, ixc_readback_fifo: storage array, pointers and count, with push/pop/full/empty.
- The top level adds the drop/ovf/clr logic.
- Storage is plain registers; no RAM macro.

## Test plan
- Reset then idle: after rst, all outputs 0; with cap=0 for 10 cycles, rd_valid stays 0.
- Single capture: R=0x1ABC, cap for 1 cycle, rd_ready=0 → next cycle rd_valid=1, rd_data=0x1ABC, count=1; assert rd_ready → count=0, rd_valid=0.
- Fill and overflow: 6 consecutive caps of 0x0001..0x0006 with rd_ready=0 → count=4, ovf=1, drops=2; drain reads 0x0001..0x0004 in order.
- Full push+pop: FIFO full, cap (R=0x0FFF) with rd_ready=1 in the same cycle → count stays 4, ovf unchanged; 0x0FFF is the last entry drained.
- Drop saturation and clr: 300 drops with CNTW=8 → drops=0xFF. clr alone → ovf=0, drops=0. clr plus a drop in the same cycle → ovf=1, drops=1.
- Reset mid-stream: 3 entries held, rst for 1 cycle with cap=1 → count=0, rd_valid=0; the next cap of 0x0AAA reads back as the only entry.

Source files
------------

// File: rtl/ixc_readback_pkg.sv
// Shared defaults and helpers for the 13-bit net-readback capture block.
package ixc_readback_pkg;

  localparam int WIDTH_DEF = 13;
  localparam int DEPTH_DEF = 4;
  localparam int CNTW_DEF  = 8;

  // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [ptr_w(DEPTH_DEF):0] count_t;

endpackage

// File: rtl/ixc_readback_fifo.sv
// Register-based FIFO holding captured net samples; full/empty derive from occupancy.
module ixc_readback_fifo
  import ixc_readback_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_req,
  input  logic                      pop_req,
  input  logic [WIDTH-1:0]          wdata,
  output logic                      push,
  output logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH):0]     count,
  output logic [WIDTH-1:0]          head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_p0 [DEPTH];
  logic [PW-1:0]    wr_ptr_p0;
  logic [PW-1:0]    rd_ptr_p0;
  logic [CW-1:0]    cnt_p0;

  assign empty = (cnt_p0 == '0);
  assign full  = (cnt_p0 == CW'(DEPTH));
  assign pop   = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = push_req & (~full | pop);
  assign count = cnt_p0;
  assign head  = mem_p0[rd_ptr_p0];

  // Stage p0: storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_p0[i] <= '0;
    end else begin
      if (push) begin
        mem_p0[wr_ptr_p0] <= wdata;
        wr_ptr_p0         <= wr_ptr_p0 + PW'(1);
      end
      if (pop) rd_ptr_p0 <= rd_ptr_p0 + PW'(1);
      case ({push, pop})
        2'b10:   cnt_p0 <= cnt_p0 + CW'(1);
        2'b01:   cnt_p0 <= cnt_p0 - CW'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

endmodule

// File: rtl/ixc_readback_13.sv
// Net-readback capture: samples R on cap into a FIFO drained by a valid/ready host port.
module ixc_readback_13
  import ixc_readback_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      R,
  input  logic                  cap,
  input  logic                  clr,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ready,
  output logic [ptr_w(DEPTH):0] count,
  output logic                  ovf,
  output logic [CNTW-1:0]       drops
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  logic            ovf_p0;
  logic [CNTW-1:0] drops_p0;

  ixc_readback_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (cap),
    .pop_req  (rd_ready),
    .wdata    (R),
    .push     (push),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (rd_data)
  );

  assign drop     = cap & full & ~pop;
  assign rd_valid = ~empty;
  assign ovf      = ovf_p0;
  assign drops    = drops_p0;

  // Stage p0: overflow bookkeeping; a drop outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p0   <= 1'b0;
      drops_p0 <= '0;
    end else if (drop) begin
      ovf_p0   <= 1'b1;
      drops_p0 <= clr ? CNTW'(1) : sat_inc(drops_p0);
    end else if (clr) begin
      ovf_p0   <= 1'b0;
      drops_p0 <= '0;
    end
  end

endmodule

// File: tb/tb_ixc_readback_13.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_ixc_readback_13;

  localparam int DEPTH = 4;
  localparam int MAXD  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] R = '0;
  logic        cap = 1'b0;
  logic        clr = 1'b0;
  logic        rd_valid;
  logic [12:0] rd_data;
  logic        rd_ready = 1'b0;
  logic [2:0]  count;
  logic        ovf;
  logic [7:0]  drops;

  int n_chk  = 0;
  int n_fail = 0;

  logic [12:0] q [$];
  bit          m_ovf   = 1'b0;
  int          m_drops = 0;

  always #5 clk = ~clk;

  ixc_readback_13 dut (
    .clk      (clk),
    .rst      (rst),
    .R        (R),
    .cap      (cap),
    .clr      (clr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .count    (count),
    .ovf      (ovf),
    .drops    (drops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(q.size()));
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("drops", 32'(drops), 32'(m_drops));
  endtask

  // Apply one cycle of inputs, advance the model by the same cycle, then compare.
  task automatic step(input bit c, input logic [12:0] r, input bit rdy, input bit cl, input bit rs);
    bit do_pop, accept, dropped;
    cap = c; R = r; rd_ready = rdy; clr = cl; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 0;
      m_drops = 0;
    end else begin
      do_pop  = rdy && (q.size() > 0);
      accept  = c && (q.size() < DEPTH || do_pop);
      dropped = c && !accept;
      if (do_pop) void'(q.pop_front());
      if (accept) q.push_back(r);
      if (dropped) begin
        m_ovf   = 1;
        m_drops = cl ? 1 : ((m_drops < MAXD) ? m_drops + 1 : MAXD);
      end else if (cl) begin
        m_ovf   = 0;
        m_drops = 0;
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    // Reset and idle
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    for (int i = 0; i < 10; i++) step(0, 13'h1FFF, 0, 0, 0);
    chk("idle_valid", 32'(rd_valid), 32'h0);

    // Single capture and pop
    step(1, 13'h1ABC, 0, 0, 0);
    chk("single_data", 32'(rd_data), 32'h1ABC);
    chk("single_count", 32'(count), 32'h1);
    step(0, 0, 1, 0, 0);
    chk("single_pop_valid", 32'(rd_valid), 32'h0);

    // Fill past depth, then drain in order
    for (int i = 1; i <= 6; i++) step(1, 13'(i), 0, 0, 0);
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_ovf", 32'(ovf), 32'h1);
    chk("fill_drops", 32'(drops), 32'h2);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      step(0, 0, 1, 0, 0);
    end

    // Push and pop together while full
    for (int i = 0; i < 4; i++) step(1, 13'h0100 + 13'(i), 0, 0, 0);
    step(1, 13'h0FFF, 1, 0, 0);
    chk("fullpp_count", 32'(count), 32'h4);
    chk("fullpp_drops", 32'(drops), 32'h2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("fullpp_last", 32'(rd_data), 32'h0FFF);
    step(0, 0, 1, 0, 0);

    // Simultaneous push and pop on an empty FIFO
    step(1, 13'h0555, 1, 0, 0);
    chk("emptypp_count", 32'(count), 32'h1);
    step(0, 0, 1, 0, 0);

    // Saturation and clear
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 13'(i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 13'(i), 0, 0, 0);
    chk("sat_drops", 32'(drops), 32'hFF);
    step(0, 0, 0, 1, 0);
    chk("clr_ovf", 32'(ovf), 32'h0);
    chk("clr_drops", 32'(drops), 32'h0);
    step(1, 13'h0005, 0, 1, 0);
    chk("clrdrop_ovf", 32'(ovf), 32'h1);
    chk("clrdrop_drops", 32'(drops), 32'h1);

    // Reset mid-stream with a capture in the reset cycle
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 13'h0200 + 13'(i), 0, 0, 0);
    step(1, 13'h0123, 0, 0, 1);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_valid", 32'(rd_valid), 32'h0);
    step(1, 13'h0AAA, 0, 0, 0);
    chk("midrst_data", 32'(rd_data), 32'h0AAA);
    step(0, 0, 1, 0, 0);
    chk("midrst_empty", 32'(count), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60),
           13'($urandom),
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 999) < 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
